// File: rtl/mem_pkg.sv
// Shared definitions for the memory responder: FSM states, access sizes
// and the alignment rule used by the fault check.
package mem_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_WAIT   = 2'b01,
    ST_ACCESS = 2'b10,
    ST_RESP   = 2'b11
  } state_e;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_RSVD = 2'b11;

  // Reserved size is reported as misaligned so it folds into the same fault.
  function automatic logic is_aligned(input logic [1:0] lane, input logic [1:0] size);
    logic ok;
    case (size)
      SZ_BYTE: ok = 1'b1;
      SZ_HALF: ok = ~lane[0];
      SZ_WORD: ok = (lane == 2'b00);
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Combinational lane steering: read-side extract/extend and write-side
// byte enables with lane-replicated data.
module mem_lane_align
  import mem_pkg::*;
(
  input  logic [31:0] rd_word,
  input  logic [1:0]  lane,
  input  logic [1:0]  size,
  input  logic        uns,
  input  logic [31:0] wdata,
  output logic [31:0] rd_val,
  output logic [3:0]  be,
  output logic [31:0] wr_word
);

  logic [31:0] shifted_s;

  assign shifted_s = rd_word >> {lane, 3'b000};

  // Read path: move the addressed lane to bit 0 and extend it.
  always_comb begin
    rd_val = 32'h0000_0000;
    case (size)
      SZ_BYTE: begin
        if (uns) begin
          rd_val = {24'h00_0000, shifted_s[7:0]};
        end else begin
          rd_val = {{24{shifted_s[7]}}, shifted_s[7:0]};
        end
      end
      SZ_HALF: begin
        if (uns) begin
          rd_val = {16'h0000, shifted_s[15:0]};
        end else begin
          rd_val = {{16{shifted_s[15]}}, shifted_s[15:0]};
        end
      end
      SZ_WORD: rd_val = rd_word;
      default: rd_val = 32'h0000_0000;
    endcase
  end

  // Write path: replicate the right-aligned data into every lane it could hit.
  always_comb begin
    be      = 4'b0000;
    wr_word = 32'h0000_0000;
    case (size)
      SZ_BYTE: begin
        be      = 4'b0001 << lane;
        wr_word = {4{wdata[7:0]}};
      end
      SZ_HALF: begin
        if (lane[1]) begin
          be = 4'b1100;
        end else begin
          be = 4'b0011;
        end
        wr_word = {2{wdata[15:0]}};
      end
      SZ_WORD: begin
        be      = 4'b1111;
        wr_word = wdata;
      end
      default: begin
        be      = 4'b0000;
        wr_word = 32'h0000_0000;
      end
    endcase
  end

endmodule

// File: rtl/mem_responder.sv
// Memory-side responder: latches one request, waits WAIT_CYCLES, accesses
// the word RAM and returns a registered single-cycle ready/err/rdata.
module mem_responder
  import mem_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        we,
  input  logic [31:0] addr,
  input  logic [1:0]  size,
  input  logic        uns,
  input  logic [31:0] wdata,
  output logic        ready,
  output logic [31:0] rdata,
  output logic        err
);

  localparam int AW = $clog2(DEPTH_WORDS);
  localparam logic [3:0] CNT_LOAD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

  state_e      state_r, state_n_s;
  logic [3:0]  cnt_r, cnt_n_s;
  logic        latch_s;
  logic        we_r, uns_r;
  logic [31:0] addr_r, wdata_r;
  logic [1:0]  size_r;
  logic        ready_r, ready_n_s;
  logic        err_r, err_n_s;
  logic [31:0] rdata_r, rdata_n_s;

  logic [31:0] mem_r [DEPTH_WORDS];

  logic          fault_s;
  logic [AW-1:0] word_idx_s;
  logic [31:0]   rd_word_s, rd_val_s, wr_word_s;
  logic [3:0]    be_s;
  logic          wr_en_s;

  assign fault_s    = !is_aligned(addr_r[1:0], size_r) || (addr_r[31:2] >= 30'(DEPTH_WORDS));
  assign word_idx_s = addr_r[AW+1:2];
  assign rd_word_s  = mem_r[word_idx_s];
  assign wr_en_s    = (state_r == ST_ACCESS) && we_r && !fault_s;

  mem_lane_align u_align (
    .rd_word (rd_word_s),
    .lane    (addr_r[1:0]),
    .size    (size_r),
    .uns     (uns_r),
    .wdata   (wdata_r),
    .rd_val  (rd_val_s),
    .be      (be_s),
    .wr_word (wr_word_s)
  );

  // Next-state, wait counter and response values for the RESP cycle.
  always_comb begin
    state_n_s = state_r;
    cnt_n_s   = cnt_r;
    latch_s   = 1'b0;
    ready_n_s = 1'b0;
    err_n_s   = 1'b0;
    rdata_n_s = 32'h0000_0000;
    case (state_r)
      ST_IDLE: begin
        if (req) begin
          latch_s = 1'b1;
          if (WAIT_CYCLES > 0) begin
            state_n_s = ST_WAIT;
            cnt_n_s   = CNT_LOAD;
          end else begin
            state_n_s = ST_ACCESS;
          end
        end else begin
          state_n_s = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (cnt_r == 4'd0) begin
          state_n_s = ST_ACCESS;
        end else begin
          cnt_n_s = cnt_r - 4'd1;
        end
      end
      ST_ACCESS: begin
        state_n_s = ST_RESP;
        ready_n_s = 1'b1;
        err_n_s   = fault_s;
        if (fault_s || we_r) begin
          rdata_n_s = 32'h0000_0000;
        end else begin
          rdata_n_s = rd_val_s;
        end
      end
      ST_RESP: state_n_s = ST_IDLE;
      default: state_n_s = ST_IDLE;
    endcase
  end

  // Control state, request latch and registered response outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r <= ST_IDLE;
      cnt_r   <= 4'd0;
      we_r    <= 1'b0;
      addr_r  <= 32'h0000_0000;
      size_r  <= 2'b00;
      uns_r   <= 1'b0;
      wdata_r <= 32'h0000_0000;
      ready_r <= 1'b0;
      err_r   <= 1'b0;
      rdata_r <= 32'h0000_0000;
    end else begin
      state_r <= state_n_s;
      cnt_r   <= cnt_n_s;
      ready_r <= ready_n_s;
      err_r   <= err_n_s;
      rdata_r <= rdata_n_s;
      if (latch_s) begin
        we_r    <= we;
        addr_r  <= addr;
        size_r  <= size;
        uns_r   <= uns;
        wdata_r <= wdata;
      end
    end
  end

  // Storage array; contents deliberately survive reset.
  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (wr_en_s && be_s[i]) begin
        mem_r[word_idx_s][8*i +: 8] <= wr_word_s[8*i +: 8];
      end
    end
  end

  assign ready = ready_r;
  assign err   = err_r;
  assign rdata = rdata_r;

endmodule

// File: tb/tb_mem_responder.sv
// Self-checking bench: directed scenarios plus random traffic against a
// byte-array reference model; one responder with 2 wait states, one with 0.
module tb_mem_responder;

  localparam int DEPTH = 1024;
  localparam int W2    = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic        req, we, uns, sel;
  logic [31:0] addr, wdata;
  logic [1:0]  size;
  logic        ready2, err2, ready0, err0;
  logic [31:0] rdata2, rdata0;
  logic        req2, req0, ready_m, err_m;
  logic [31:0] rdata_m;

  int vectors = 0;
  int miscompares = 0;

  logic [7:0] mdl2 [256];
  logic [7:0] mdl0 [256];

  always #5 clk = ~clk;

  assign req2    = req & ~sel;
  assign req0    = req & sel;
  assign ready_m = sel ? ready0 : ready2;
  assign err_m   = sel ? err0 : err2;
  assign rdata_m = sel ? rdata0 : rdata2;

  mem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(W2)) u_dut (
    .clk(clk), .reset(reset), .req(req2), .we(we), .addr(addr), .size(size),
    .uns(uns), .wdata(wdata), .ready(ready2), .rdata(rdata2), .err(err2)
  );

  mem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(0)) u_dut0 (
    .clk(clk), .reset(reset), .req(req0), .we(we), .addr(addr), .size(size),
    .uns(uns), .wdata(wdata), .ready(ready0), .rdata(rdata0), .err(err0)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] mget(input bit s, input int i);
    return s ? mdl0[i] : mdl2[i];
  endfunction

  function automatic void mset(input bit s, input int i, input logic [7:0] v);
    if (s) mdl0[i] = v;
    else   mdl2[i] = v;
  endfunction

  // Reference: little-endian byte memory, fault rules applied directly.
  function automatic void model(input bit s, input bit w_i, input logic [31:0] a,
                                input logic [1:0] sz, input bit un, input logic [31:0] wd,
                                output bit e, output logic [31:0] rd);
    int n;
    e  = (sz == 2'd3) || (sz == 2'd1 && a[0]) || (sz == 2'd2 && a[1:0] != 2'd0)
         || (a >= 32'(DEPTH * 4));
    rd = 32'h0;
    if (e) return;
    n = 1 << sz;
    if (w_i) begin
      for (int i = 0; i < n; i++) mset(s, int'(a) + i, wd[8*i +: 8]);
    end else begin
      for (int i = 0; i < n; i++) rd[8*i +: 8] = mget(s, int'(a) + i);
      if (!un && n < 4 && rd[8*n-1]) begin
        for (int j = n; j < 4; j++) rd[8*j +: 8] = 8'hFF;
      end
    end
  endfunction

  task automatic do_txn(input bit s, input bit w_i, input logic [31:0] a, input logic [1:0] sz,
                        input bit un, input logic [31:0] wd,
                        output logic [31:0] rd_obs, output logic err_obs);
    bit          e_exp;
    logic [31:0] rd_exp;
    int          k;
    bit          got;
    model(s, w_i, a, sz, un, wd, e_exp, rd_exp);
    @(negedge clk);
    sel = s; we = w_i; addr = a; size = sz; uns = un; wdata = wd; req = 1'b1;
    k = 0; got = 1'b0;
    while (!got && k < 40) begin
      @(posedge clk); #1;
      k++;
      if (k == 1) begin
        addr = $urandom; wdata = $urandom; we = ~w_i; size = ~sz; uns = ~un;
      end
      if (ready_m) got = 1'b1;
    end
    chk("latency", 32'(k), s ? 32'd2 : 32'(W2 + 2));
    chk("err", {31'd0, err_m}, {31'd0, e_exp});
    chk("rdata", rdata_m, rd_exp);
    rd_obs  = rdata_m;
    err_obs = err_m;
    @(negedge clk);
    req = 1'b0;
    @(posedge clk); #1;
    chk("ready_drop", {31'd0, ready_m}, 32'd0);
  endtask

  initial begin
    logic [31:0] rd, a, wd;
    logic        e, w_i, un;
    logic [1:0]  sz;
    bit          eb;
    logic [31:0] rx;
    int          k;

    reset = 1'b0; req = 1'b0; sel = 1'b0; we = 1'b0; addr = 32'h0;
    size = 2'b00; uns = 1'b0; wdata = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready2", {31'd0, ready2}, 32'd0);
    chk("rst_err2", {31'd0, err2}, 32'd0);
    chk("rst_rdata2", rdata2, 32'd0);
    chk("rst_ready0", {31'd0, ready0}, 32'd0);
    @(negedge clk);
    reset = 1'b1;

    for (int i = 0; i < 64; i++) do_txn(1'b0, 1'b1, 32'(i * 4), 2'b10, 1'b0, $urandom, rd, e);

    do_txn(1'b0, 1'b1, 32'h10, 2'b10, 1'b0, 32'hDEADBEEF, rd, e);
    do_txn(1'b0, 1'b0, 32'h10, 2'b10, 1'b0, 32'h0, rd, e);
    chk("rt_word", rd, 32'hDEADBEEF);
    chk("rt_err", {31'd0, e}, 32'd0);

    do_txn(1'b0, 1'b1, 32'h20, 2'b10, 1'b0, 32'h11223344, rd, e);
    do_txn(1'b0, 1'b1, 32'h21, 2'b00, 1'b0, 32'h00000080, rd, e);
    do_txn(1'b0, 1'b0, 32'h20, 2'b10, 1'b0, 32'h0, rd, e);
    chk("lane_word", rd, 32'h11228044);
    do_txn(1'b0, 1'b0, 32'h21, 2'b00, 1'b0, 32'h0, rd, e);
    chk("lane_sbyte", rd, 32'hFFFFFF80);
    do_txn(1'b0, 1'b0, 32'h21, 2'b00, 1'b1, 32'h0, rd, e);
    chk("lane_ubyte", rd, 32'h00000080);
    do_txn(1'b0, 1'b0, 32'h22, 2'b01, 1'b0, 32'h0, rd, e);
    chk("lane_shalf", rd, 32'h00001122);

    do_txn(1'b0, 1'b0, 32'h22, 2'b10, 1'b0, 32'h0, rd, e);
    chk("flt_word_mis", {31'd0, e}, 32'd1);
    chk("flt_word_rd", rd, 32'd0);
    do_txn(1'b0, 1'b0, 32'h30, 2'b10, 1'b0, 32'h0, rx, e);
    do_txn(1'b0, 1'b1, 32'h31, 2'b01, 1'b0, 32'h0000FFFF, rd, e);
    chk("flt_half_mis", {31'd0, e}, 32'd1);
    do_txn(1'b0, 1'b0, 32'h30, 2'b10, 1'b0, 32'h0, rd, e);
    chk("flt_half_nowr", rd, rx);
    do_txn(1'b0, 1'b0, 32'(DEPTH * 4), 2'b10, 1'b0, 32'h0, rd, e);
    chk("flt_range", {31'd0, e}, 32'd1);
    do_txn(1'b0, 1'b0, 32'h8, 2'b11, 1'b0, 32'h0, rd, e);
    chk("flt_rsvd", {31'd0, e}, 32'd1);

    for (int i = 0; i < 80; i++) begin
      a = 32'($urandom_range(0, 255));
      if ($urandom_range(0, 7) == 0) sz = 2'b11;
      else sz = 2'($urandom_range(0, 2));
      if ($urandom_range(0, 3) != 0) begin
        if (sz == 2'b01) a[0] = 1'b0;
        if (sz == 2'b10) a[1:0] = 2'b00;
      end
      if ($urandom_range(0, 15) == 0) a = 32'(DEPTH * 4) + 32'($urandom_range(0, 4095));
      w_i = 1'($urandom_range(0, 1));
      un  = 1'($urandom_range(0, 1));
      wd  = $urandom;
      do_txn(1'b0, w_i, a, sz, un, wd, rd, e);
    end

    // Reset while a write sits in WAIT: no ready, no commit.
    do_txn(1'b0, 1'b1, 32'h40, 2'b10, 1'b0, 32'h12345678, rd, e);
    @(negedge clk);
    sel = 1'b0; we = 1'b1; addr = 32'h40; size = 2'b10; uns = 1'b0;
    wdata = 32'hCAFEF00D; req = 1'b1;
    @(posedge clk); #1;
    chk("rst_mid_wait", {31'd0, ready2}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("rst_mid_low", {31'd0, ready2}, 32'd0);
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      chk("rst_mid_hold", {31'd0, ready2}, 32'd0);
    end
    req = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      chk("rst_mid_after", {31'd0, ready2}, 32'd0);
    end
    do_txn(1'b0, 1'b0, 32'h40, 2'b10, 1'b0, 32'h0, rd, e);
    chk("rst_mid_old", rd, 32'h12345678);

    // Back-to-back on the zero-wait responder with req held high.
    model(1'b1, 1'b1, 32'h10, 2'b10, 1'b0, 32'hA5A55A5A, eb, rx);
    @(negedge clk);
    sel = 1'b1; we = 1'b1; addr = 32'h10; size = 2'b10; uns = 1'b0;
    wdata = 32'hA5A55A5A; req = 1'b1;
    k = 0;
    do begin
      @(posedge clk); #1;
      k++;
    end while (!ready0 && k < 20);
    chk("b2b_lat1", 32'(k), 32'd2);
    chk("b2b_err1", {31'd0, err0}, 32'd0);
    chk("b2b_rd1", rdata0, 32'd0);
    model(1'b1, 1'b0, 32'h10, 2'b10, 1'b0, 32'h0, eb, rx);
    we = 1'b0; wdata = 32'h0;
    k = 0;
    do begin
      @(posedge clk); #1;
      k++;
    end while (!ready0 && k < 20);
    chk("b2b_gap", 32'(k), 32'd3);
    chk("b2b_err2", {31'd0, err0}, 32'd0);
    chk("b2b_rd2", rdata0, rx);
    chk("b2b_rd2_const", rdata0, 32'hA5A55A5A);
    @(negedge clk);
    req = 1'b0;
    @(posedge clk); #1;
    chk("b2b_drop", {31'd0, ready0}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
